// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage: NPORTS register write channels plus HI/LO, carried through
// a two-entry (main + skid) valid/ready buffer with flush, $0 masking and a retire counter.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NPORTS = 2,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NPORTS*ADDR_W-1:0] w_addr_in,
  input  logic [NPORTS*DATA_W-1:0] w_data_in,
  input  logic [NPORTS-1:0]        w_en_in,
  input  logic [DATA_W-1:0]        hi_in,
  input  logic [DATA_W-1:0]        lo_in,
  input  logic                     hilo_wen_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NPORTS*ADDR_W-1:0] w_addr_out,
  output logic [NPORTS*DATA_W-1:0] w_data_out,
  output logic [NPORTS-1:0]        w_en_out,
  output logic [DATA_W-1:0]        hi_out,
  output logic [DATA_W-1:0]        lo_out,
  output logic                     hilo_wen_out,
  output logic [CNT_W-1:0]         retire_cnt
);

  localparam int PW = NPORTS*ADDR_W + NPORTS*DATA_W + NPORTS + 2*DATA_W + 1;

  // Handshake: a beat moves on any edge where valid and ready are both high;
  // valid never depends on ready, and in_ready comes straight from a flop.
  logic [PW-1:0]    in_pl;
  logic [PW-1:0]    main_pl_q, main_pl_d;
  logic [PW-1:0]    skid_pl_q, skid_pl_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [NPORTS-1:0] main_en;
  logic             main_hilo_wen;
  logic             accept, emit;

  assign in_pl = {hilo_wen_in, hi_in, lo_in, w_en_in, w_data_in, w_addr_in};
  assign {main_hilo_wen, hi_out, lo_out, main_en, w_data_out, w_addr_out} = main_pl_q;

  assign in_ready   = !skid_valid_q;
  assign out_valid  = main_valid_q;
  assign retire_cnt = retire_cnt_q;
  assign accept     = in_valid & in_ready;
  assign emit       = main_valid_q & out_ready;

  always_comb begin
    main_pl_d    = main_pl_q;
    skid_pl_d    = skid_pl_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    retire_cnt_d = retire_cnt_q;
    // An emit in a flush cycle was already consumed by WB, so it still counts.
    if (emit) retire_cnt_d = retire_cnt_q + CNT_W'(1);
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || emit) begin
      if (skid_valid_q) begin
        main_pl_d    = skid_pl_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
        if (accept) begin
          skid_pl_d    = in_pl;
          skid_valid_d = 1'b1;
        end
      end else if (accept) begin
        main_pl_d    = in_pl;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_pl_d    = in_pl;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_pl_q    <= '0;
      skid_pl_q    <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      main_pl_q    <= main_pl_d;
      skid_pl_q    <= skid_pl_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Writes to $0 are dropped; on an address collision the highest-index port wins.
  always_comb begin
    w_en_out = '0;
    for (int i = 0; i < NPORTS; i++) begin
      w_en_out[i] = main_valid_q & main_en[i] &
                    (w_addr_out[i*ADDR_W +: ADDR_W] != '0);
      for (int j = i + 1; j < NPORTS; j++) begin
        if (main_en[j] && (w_addr_out[j*ADDR_W +: ADDR_W] == w_addr_out[i*ADDR_W +: ADDR_W]))
          w_en_out[i] = 1'b0;
      end
    end
  end

  assign hilo_wen_out = main_valid_q & main_hilo_wen;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: streaming, backpressure, collisions, flush, HI/LO,
// reset mid-stream and retire counter wrap (second instance with a 4-bit counter).
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready, hilo_wen_in;
  logic [9:0]  w_addr_in;
  logic [63:0] w_data_in;
  logic [1:0]  w_en_in;
  logic [31:0] hi_in, lo_in;
  logic        in_ready, out_valid, hilo_wen_out;
  logic [9:0]  w_addr_out;
  logic [63:0] w_data_out;
  logic [1:0]  w_en_out;
  logic [31:0] hi_out, lo_out, retire_cnt;
  logic        o4_in_ready, o4_out_valid, o4_hilo_wen_out;
  logic [9:0]  o4_w_addr_out;
  logic [63:0] o4_w_data_out;
  logic [1:0]  o4_w_en_out;
  logic [31:0] o4_hi_out, o4_lo_out;
  logic [3:0]  o4_retire_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .NPORTS(2), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .w_addr_in(w_addr_in), .w_data_in(w_data_in), .w_en_in(w_en_in),
    .hi_in(hi_in), .lo_in(lo_in), .hilo_wen_in(hilo_wen_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .w_addr_out(w_addr_out), .w_data_out(w_data_out), .w_en_out(w_en_out),
    .hi_out(hi_out), .lo_out(lo_out), .hilo_wen_out(hilo_wen_out), .retire_cnt(retire_cnt)
  );

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .NPORTS(2), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o4_in_ready),
    .w_addr_in(w_addr_in), .w_data_in(w_data_in), .w_en_in(w_en_in),
    .hi_in(hi_in), .lo_in(lo_in), .hilo_wen_in(hilo_wen_in),
    .out_valid(o4_out_valid), .out_ready(out_ready),
    .w_addr_out(o4_w_addr_out), .w_data_out(o4_w_data_out), .w_en_out(o4_w_en_out),
    .hi_out(o4_hi_out), .lo_out(o4_lo_out), .hilo_wen_out(o4_hilo_wen_out),
    .retire_cnt(o4_retire_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [4:0] a0, input logic [31:0] d0,
                          input logic [4:0] a1, input logic [31:0] d1, input logic [1:0] en);
    w_addr_in = {a1, a0};
    w_data_in = {d1, d0};
    w_en_in   = en;
    in_valid  = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; hilo_wen_in = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_beat(5'd7, 32'h1234, 5'd8, 32'h5678, 2'b11);
    hilo_wen_in = 1'b1; hi_in = 32'hFFFF_0000; lo_in = 32'h0000_FFFF;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || w_en_out !== 2'b00 || hilo_wen_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: valid=%b ready=%b en=%b hilo=%b, want 0 1 00 0",
               out_valid, in_ready, w_en_out, hilo_wen_out);
    end
    n_checks++;
    if (retire_cnt !== 32'd0 || w_data_out !== 64'd0 || w_addr_out !== 10'd0 ||
        hi_out !== 32'd0 || lo_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_payload: cnt=%0d data=%h addr=%h hi=%h lo=%h, want all 0",
               retire_cnt, w_data_out, w_addr_out, hi_out, lo_out);
    end
    rst_n = 1'b1; in_valid = 1'b0; hilo_wen_in = 1'b0;
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_beat(5'(i + 1), 32'h100 + i, 5'd0, 32'd0, 2'b01);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || w_data_out[31:0] !== 32'h100 + i ||
          w_addr_out[4:0] !== 5'(i + 1) || w_en_out !== 2'b01) begin
        n_fail++;
        $display("FAIL stream_beat%0d: valid=%b addr=%0d data=%h en=%b, want 1 %0d %h 01",
                 i, out_valid, w_addr_out[4:0], w_data_out[31:0], w_en_out, i + 1, 32'h100 + i);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (retire_cnt !== 32'd8 || out_valid !== 1'b0 || w_en_out !== 2'b00) begin
      n_fail++;
      $display("FAIL stream_end: cnt=%0d valid=%b en=%b, want 8 0 00", retire_cnt, out_valid, w_en_out);
    end
  endtask

  task automatic test_backpressure();
    int nb;
    logic exp_rdy, exp_valid;
    logic [31:0] want;
    do_reset();
    exp_q.delete();
    nb = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = (nb < 5);
      if (nb < 5) set_beat(5'(nb + 1), 32'h200 + nb, 5'd0, 32'd0, 2'b01);
      out_ready = !(cyc >= 2 && cyc <= 4);
      exp_rdy   = !(cyc >= 3 && cyc <= 5);
      exp_valid = (exp_q.size() != 0);
      n_checks++;
      if (in_ready !== exp_rdy || out_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL bp_hs cyc%0d: ready=%b valid=%b, want %b %b", cyc, in_ready, out_valid, exp_rdy, exp_valid);
      end
      if (exp_valid && out_ready) begin
        want = exp_q.pop_front();
        n_checks++;
        if (w_data_out[31:0] !== want) begin
          n_fail++;
          $display("FAIL bp_data cyc%0d: data=%h, want %h", cyc, w_data_out[31:0], want);
        end
      end
      if (in_valid && exp_rdy) begin
        exp_q.push_back(32'h200 + nb);
        nb++;
      end
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (nb != 5 || exp_q.size() != 0 || retire_cnt !== 32'd5) begin
      n_fail++;
      $display("FAIL bp_end: sent=%0d left=%0d cnt=%0d, want 5 0 5", nb, exp_q.size(), retire_cnt);
    end
  endtask

  task automatic test_collision();
    do_reset();
    out_ready = 1'b0;
    set_beat(5'd3, 32'hA, 5'd3, 32'hB, 2'b11);
    tick();
    n_checks++;
    if (w_en_out !== 2'b10 || w_data_out[63:32] !== 32'hB) begin
      n_fail++;
      $display("FAIL collide: en=%b d1=%h, want 10 0000000b", w_en_out, w_data_out[63:32]);
    end
    out_ready = 1'b1;
    set_beat(5'd0, 32'hC, 5'd5, 32'hD, 2'b01);
    tick();
    n_checks++;
    if (w_en_out !== 2'b00 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_mask: en=%b valid=%b, want 00 1", w_en_out, out_valid);
    end
    set_beat(5'd4, 32'h1, 5'd4, 32'h2, 2'b01);
    tick();
    n_checks++;
    if (w_en_out !== 2'b01) begin
      n_fail++;
      $display("FAIL collide_dis: en=%b, want 01", w_en_out);
    end
    set_beat(5'd4, 32'h3, 5'd7, 32'h4, 2'b11);
    tick();
    n_checks++;
    if (w_en_out !== 2'b11) begin
      n_fail++;
      $display("FAIL distinct: en=%b, want 11", w_en_out);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    set_beat(5'd1, 32'hC0, 5'd0, 32'd0, 2'b01);
    tick();
    set_beat(5'd2, 32'hC1, 5'd0, 32'd0, 2'b01);
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full: ready=%b valid=%b, want 0 1", in_ready, out_valid);
    end
    flush = 1'b1;
    set_beat(5'd3, 32'hC2, 5'd0, 32'd0, 2'b01);
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || retire_cnt !== 32'd0 || w_en_out !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_clear: valid=%b ready=%b cnt=%0d en=%b, want 0 1 0 00",
               out_valid, in_ready, retire_cnt, w_en_out);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ghost: valid=%b data=%h, want 0", out_valid, w_data_out[31:0]);
    end
    set_beat(5'd9, 32'h5D0, 5'd0, 32'd0, 2'b01);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || w_data_out[31:0] !== 32'h5D0) begin
      n_fail++;
      $display("FAIL flush_after: valid=%b data=%h, want 1 000005d0", out_valid, w_data_out[31:0]);
    end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (retire_cnt !== 32'd1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_emit: cnt=%0d valid=%b, want 1 0", retire_cnt, out_valid);
    end
  endtask

  task automatic test_hilo();
    do_reset();
    out_ready = 1'b1;
    set_beat(5'd0, 32'd0, 5'd0, 32'd0, 2'b00);
    hilo_wen_in = 1'b1; hi_in = 32'hDEAD_0000; lo_in = 32'h0000_BEEF;
    tick();
    n_checks++;
    if (hilo_wen_out !== 1'b1 || hi_out !== 32'hDEAD_0000 || lo_out !== 32'h0000_BEEF) begin
      n_fail++;
      $display("FAIL hilo_beat: wen=%b hi=%h lo=%h, want 1 dead0000 0000beef", hilo_wen_out, hi_out, lo_out);
    end
    in_valid = 1'b0; hilo_wen_in = 1'b0;
    tick();
    n_checks++;
    if (hilo_wen_out !== 1'b0 || out_valid !== 1'b0 || retire_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL hilo_once: wen=%b valid=%b cnt=%0d, want 0 0 1", hilo_wen_out, out_valid, retire_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    set_beat(5'd1, 32'hE0, 5'd0, 32'd0, 2'b01);
    tick();
    set_beat(5'd2, 32'hE1, 5'd0, 32'd0, 2'b01);
    tick();
    out_ready = 1'b0;
    set_beat(5'd3, 32'hE2, 5'd0, 32'd0, 2'b01);
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || retire_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL rmid_pre: ready=%b cnt=%0d, want 0 1", in_ready, retire_cnt);
    end
    rst_n = 1'b0;
    set_beat(5'd4, 32'hE3, 5'd0, 32'd0, 2'b01);
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || w_en_out !== 2'b00 || hilo_wen_out !== 1'b0 ||
        retire_cnt !== 32'd0 || w_data_out !== 64'd0 || w_addr_out !== 10'd0) begin
      n_fail++;
      $display("FAIL rmid_reset: valid=%b ready=%b en=%b cnt=%0d data=%h addr=%h, want 0 1 00 0 0 0",
               out_valid, in_ready, w_en_out, retire_cnt, w_data_out, w_addr_out);
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || retire_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL rmid_after: valid=%b cnt=%0d, want 0 0", out_valid, retire_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_beat(5'd1, 32'h300 + i, 5'd0, 32'd0, 2'b01);
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (o4_retire_cnt !== 4'd1 || retire_cnt !== 32'd17) begin
      n_fail++;
      $display("FAIL cnt_wrap: cnt4=%0d cnt32=%0d, want 1 17", o4_retire_cnt, retire_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; hilo_wen_in = 1'b0;
    w_addr_in = '0; w_data_in = '0; w_en_in = '0; hi_in = '0; lo_in = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_collision();
    test_flush();
    test_hilo();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM→WB pipeline stage for the MIPS core, replacing the fixed single-port register stage. Carries NPORTS register-file write channels plus the HI/LO write channel through a valid/ready, two-entry (main + skid) buffer. Adds flush, masking of $0 writes, intra-beat write-collision resolution, and a retired-beat counter. Sits between the memory stage and the register file / HI-LO unit.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- NPORTS, 2, register write channels per beat (1..4)
- CNT_W, 32, retired-beat counter width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  discard all buffered and incoming beats
- in_valid  in  1  MEM beat valid
- in_ready  out  1  stage can accept a beat
- w_addr_in  in  NPORTS*ADDR_W  write addresses, port i at bits [i*ADDR_W +: ADDR_W]
- w_data_in  in  NPORTS*DATA_W  write data, packed as above
- w_en_in  in  NPORTS  per-port write enables
- hi_in, lo_in  in  DATA_W each  HI/LO data
- hilo_wen_in  in  1  HI/LO write enable
- out_valid  out  1  WB beat valid
- out_ready  in  1  WB consumer accepts beat
- w_addr_out  out  NPORTS*ADDR_W  buffered addresses
- w_data_out  out  NPORTS*DATA_W  buffered data
- w_en_out  out  NPORTS  qualified enables (see Operation)
- hi_out, lo_out  out  DATA_W each  buffered HI/LO
- hilo_wen_out  out  1  hilo_wen & out_valid
- retire_cnt  out  CNT_W  beats handed to WB since reset

## Operation
- Storage: main entry (drives outputs) and skid entry, each with a valid bit. A beat's payload is all *_in fields captured together.
- Accept: in_valid & in_ready. Emit: out_valid & out_ready.
- in_ready registered: in_ready = !skid_valid.
- Cycle update (no flush):
  - main empty or emitted: main ← skid if skid_valid (skid clears), else main ← accepted beat, else main_valid ← 0.
  - Accept while main full and not emitted: beat → skid.
  - Accept and skid→main in same cycle: accepted beat → skid.
- Ordering strictly FIFO; no beat lost or duplicated.
- Output qualification, combinational from main entry:
  - w_en_out[i] = main_valid & en[i] & (addr[i] != 0) & no port j>i with en[j] & addr[j]==addr[i]. The highest-index port wins a collision.
  - hilo_wen_out = main_valid & hilo_wen.
  - Data and address outputs are driven unqualified.
- Flush: both valid bits cleared next edge; beat presented that cycle is discarded even if in_ready=1; retire_cnt unchanged. Flush overrides simultaneous accept/emit, except that an emit occurring that same cycle still counts (WB already consumed it).
- retire_cnt increments by 1 per emit, wraps modulo 2^CNT_W, is cleared only by reset.

## Timing
- Latency 1 cycle: beat accepted at edge N is on outputs after edge N with out_valid=1, when main was empty/emitting.
- Throughput 1 beat/cycle while out_ready=1.
- One out_ready-low cycle fills skid. in_ready drops the following cycle and returns one cycle after the skid drains.
- Reset (rst_n=0 at edge): both valid bits 0, out_valid=0, all w_en_out=0, hilo_wen_out=0, payload registers 0, retire_cnt=0, in_ready=1. Inputs during reset are ignored. Reset mid-stream discards buffered beats.
- Full (both entries valid): in_ready=0; in_valid ignored; outputs stable until out_ready.
- Empty: out_valid=0; out_ready ignored.

## Test plan
- Streaming: 8 beats, out_ready=1, port0 addr=i+1, data=0x100+i -> each on outputs 1 cycle later in order, retire_cnt=8.
- Backpressure: out_ready low 3 cycles mid-stream of 5 beats -> skid fills, in_ready=0 from the second stalled cycle, all 5 beats delivered in order, none duplicated.
- Collision/$0: port0 addr=3 data=0xA, port1 addr=3 data=0xB, both enabled -> w_en_out=2'b10. Beat with port0 addr=0 en=1 -> w_en_out[0]=0.
- Flush: both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, retire_cnt unchanged, discarded beats never appear.
- HI/LO: hilo_wen_in=1, hi=0xDEAD0000, lo=0x0000BEEF -> hilo_wen_out=1 with those values for exactly one emitted beat.
- Reset mid-operation: rst_n low 1 cycle with skid full -> all outputs at reset values, in_ready=1, retire_cnt=0. Counter wrap is checked separately with CNT_W=4: 17 emits -> retire_cnt=1.
